// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : pipeline MEM stage with req/ack data-memory access, upstream
//             stall, forwarding pair and fault reporting.
//             Optional macro MEM_SUBWORD_EN enables byte/halfword accesses.
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int DMEM_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr1_IN,
  input  logic [31:0] Instr1_PC_IN,
  input  logic [31:0] ALU_result1_IN,
  input  logic [4:0]  WriteRegister1_IN,
  input  logic [31:0] MemWriteData1_IN,
  input  logic        RegWrite1_IN,
  input  logic        MemRead1_IN,
  input  logic        MemWrite1_IN,
  input  logic [5:0]  ALU_Control1_IN,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        STALL,
  output logic [4:0]  MemWriteReg,
  output logic [31:0] Mem_ALU_result,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr1_PC_OUT,
  output logic [31:0] WriteData1_OUT,
  output logic [4:0]  WriteRegister1_OUT,
  output logic        RegWrite1_OUT,
  output logic        MemFault_OUT
);

  localparam int CW = (DMEM_TIMEOUT < 2) ? 1 : $clog2(DMEM_TIMEOUT + 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(DMEM_TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_alu;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic          r_we;
  logic [4:0]    r_wreg;
  logic          r_rw;
  logic [31:0]   r_instr;
  logic [31:0]   r_pc;

  logic          w_memop;
  logic          w_misalign;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_load;
  logic          w_timeout;
  logic          w_unused;

  assign w_memop   = MemRead1_IN | MemWrite1_IN;
  assign w_timeout = (r_cnt == c_cnt_last);

`ifdef MEM_SUBWORD_EN
  logic [1:0] r_size;
  logic       r_uns;
  logic [7:0] w_byte;
  logic [15:0] w_half;

  assign w_unused = ^ALU_Control1_IN[5:3];

  // Access size comes from the low bits of the load/store opcode: 00 byte, 01 half, 11 word.
  always_comb begin
    w_misalign = 1'b0;
    w_be       = 4'hF;
    w_wdata    = MemWriteData1_IN;
    case (ALU_Control1_IN[1:0])
      2'b00: begin
        w_be    = 4'b0001 << ALU_result1_IN[1:0];
        w_wdata = {4{MemWriteData1_IN[7:0]}};
      end
      2'b01: begin
        w_be       = ALU_result1_IN[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{MemWriteData1_IN[15:0]}};
        w_misalign = w_memop & ALU_result1_IN[0];
      end
      default: w_misalign = w_memop & (ALU_result1_IN[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    case (r_alu[1:0])
      2'b00:   w_byte = dmem_rdata[7:0];
      2'b01:   w_byte = dmem_rdata[15:8];
      2'b10:   w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_size)
      2'b00:   w_load = r_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = r_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = dmem_rdata;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_size <= 2'b00;
      r_uns  <= 1'b0;
    end else if (r_state == ST_IDLE && w_memop && !w_misalign) begin
      r_size <= ALU_Control1_IN[1:0];
      r_uns  <= ALU_Control1_IN[2];
    end
  end
`else
  assign w_unused   = ^ALU_Control1_IN;
  assign w_misalign = 1'b0;
  assign w_be       = 4'hF;
  assign w_wdata    = MemWriteData1_IN;
  assign w_load     = dmem_rdata;
`endif

  // Forwarding and stall are gated by reset so every output reads 0 while RESET is low.
  assign STALL          = RESET & (((r_state == ST_IDLE) & w_memop & ~w_misalign) |
                                   ((r_state == ST_ACCESS) & ~dmem_ack & ~w_timeout));
  assign MemWriteReg    = (RESET & RegWrite1_IN & ~MemRead1_IN) ? WriteRegister1_IN : 5'd0;
  assign Mem_ALU_result = RESET ? ALU_result1_IN : 32'h0;

  assign dmem_req   = (r_state == ST_ACCESS);
  assign dmem_we    = dmem_req & r_we;
  assign dmem_addr  = {r_alu[31:2], 2'b00};
  assign dmem_be    = r_be;
  assign dmem_wdata = r_wdata;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state            <= ST_IDLE;
      r_cnt              <= '0;
      r_alu              <= 32'h0;
      r_wdata            <= 32'h0;
      r_be               <= 4'h0;
      r_we               <= 1'b0;
      r_wreg             <= 5'd0;
      r_rw               <= 1'b0;
      r_instr            <= 32'h0;
      r_pc               <= 32'h0;
      Instr1_OUT         <= 32'h0;
      Instr1_PC_OUT      <= 32'h0;
      WriteData1_OUT     <= 32'h0;
      WriteRegister1_OUT <= 5'd0;
      RegWrite1_OUT      <= 1'b0;
      MemFault_OUT       <= 1'b0;
    end else begin
      MemFault_OUT <= 1'b0;
      if (r_state == ST_IDLE) begin
        Instr1_OUT         <= Instr1_IN;
        Instr1_PC_OUT      <= Instr1_PC_IN;
        WriteData1_OUT     <= ALU_result1_IN;
        WriteRegister1_OUT <= WriteRegister1_IN;
        if (w_memop) begin
          RegWrite1_OUT <= 1'b0;
          if (w_misalign) begin
            MemFault_OUT <= 1'b1;
          end else begin
            r_alu   <= ALU_result1_IN;
            r_wdata <= w_wdata;
            r_be    <= w_be;
            r_we    <= MemWrite1_IN;
            r_wreg  <= WriteRegister1_IN;
            r_rw    <= RegWrite1_IN;
            r_instr <= Instr1_IN;
            r_pc    <= Instr1_PC_IN;
            r_cnt   <= '0;
            r_state <= ST_ACCESS;
          end
        end else begin
          RegWrite1_OUT <= RegWrite1_IN;
        end
      end else begin
        // An ack in the timeout cycle still completes the access normally.
        if (dmem_ack) begin
          Instr1_OUT         <= r_instr;
          Instr1_PC_OUT      <= r_pc;
          WriteData1_OUT     <= r_we ? r_alu : w_load;
          WriteRegister1_OUT <= r_wreg;
          RegWrite1_OUT      <= r_rw & ~r_we;
          r_state            <= ST_IDLE;
        end else if (w_timeout) begin
          RegWrite1_OUT <= 1'b0;
          MemFault_OUT  <= 1'b1;
          r_state       <= ST_IDLE;
        end else begin
          RegWrite1_OUT <= 1'b0;
          r_cnt         <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : directed self-checking bench for mem_stage (DMEM_TIMEOUT=4).
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN;
  logic [4:0]  WriteRegister1_IN;
  logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
  logic [5:0]  ALU_Control1_IN;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        STALL;
  logic [4:0]  MemWriteReg, WriteRegister1_OUT;
  logic [31:0] Mem_ALU_result, Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT;
  logic        RegWrite1_OUT, MemFault_OUT;

  always #5 CLK = ~CLK;

  mem_stage #(.DMEM_TIMEOUT(4)) u_dut (
    .CLK(CLK), .RESET(RESET),
    .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
    .ALU_result1_IN(ALU_result1_IN), .WriteRegister1_IN(WriteRegister1_IN),
    .MemWriteData1_IN(MemWriteData1_IN), .RegWrite1_IN(RegWrite1_IN),
    .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN),
    .ALU_Control1_IN(ALU_Control1_IN),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .STALL(STALL), .MemWriteReg(MemWriteReg),
    .Mem_ALU_result(Mem_ALU_result), .Instr1_OUT(Instr1_OUT),
    .Instr1_PC_OUT(Instr1_PC_OUT), .WriteData1_OUT(WriteData1_OUT),
    .WriteRegister1_OUT(WriteRegister1_OUT), .RegWrite1_OUT(RegWrite1_OUT),
    .MemFault_OUT(MemFault_OUT)
  );

`ifdef MEM_SUBWORD_EN
  localparam logic [31:0] c_lb_data  = 32'hFFFF_FF80;
  localparam logic [31:0] c_lbu_data = 32'h0000_0080;
  localparam logic [31:0] c_lb_be    = 32'h8;
  localparam logic [31:0] c_sh_be    = 32'hC;
  localparam logic [31:0] c_sh_hi    = 32'hABCD;
  localparam logic [31:0] c_mis_reqs = 32'd0;
  localparam logic [31:0] c_mis_flt  = 32'd1;
  localparam logic [31:0] c_mis_rw   = 32'd0;
`else
  localparam logic [31:0] c_lb_data  = 32'h8012_3456;
  localparam logic [31:0] c_lbu_data = 32'h8012_3456;
  localparam logic [31:0] c_lb_be    = 32'hF;
  localparam logic [31:0] c_sh_be    = 32'hF;
  localparam logic [31:0] c_sh_hi    = 32'h0000;
  localparam logic [31:0] c_mis_reqs = 32'd1;
  localparam logic [31:0] c_mis_flt  = 32'd0;
  localparam logic [31:0] c_mis_rw   = 32'd1;
`endif

  int          n_total = 0;
  int          n_bad   = 0;
  int          stalls, reqs;
  logic        seen, done;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;
  logic [4:0]  cap_fwd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input logic [5:0] ctl, input logic [31:0] alu, input logic [4:0] wreg,
                        input logic [31:0] wd, input logic rw, input logic mr, input logic mw);
    ALU_Control1_IN   = ctl;
    ALU_result1_IN    = alu;
    WriteRegister1_IN = wreg;
    MemWriteData1_IN  = wd;
    RegWrite1_IN      = rw;
    MemRead1_IN       = mr;
    MemWrite1_IN      = mw;
    Instr1_IN         = {alu[15:0], 16'hA5A5};
    Instr1_PC_IN      = alu + 32'd4;
  endtask

  // Present one op, ack in loop cycle ack_at (cycle 0 is the IDLE cycle), run until STALL drops.
  task automatic run_mem(input logic [5:0] ctl, input logic [31:0] alu, input logic [4:0] wreg,
                         input logic [31:0] wd, input logic rw, input logic mr, input logic mw,
                         input int ack_at, input logic [31:0] rd);
    set_op(ctl, alu, wreg, wd, rw, mr, mw);
    stalls = 0; reqs = 0; seen = 1'b0; done = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      dmem_ack   = (c == ack_at);
      dmem_rdata = (c == ack_at) ? rd : 32'h0;
      #1;
      if (c == 0) cap_fwd = MemWriteReg;
      if (STALL) stalls++;
      if (dmem_req) begin
        reqs++;
        if (!seen) begin
          seen = 1'b1;
          cap_addr = dmem_addr; cap_wdata = dmem_wdata; cap_be = dmem_be; cap_we = dmem_we;
        end
      end
      done = !STALL;
      tick;
    end
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    set_op(6'h00, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("op_completes", {31'b0, done}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RESET = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    set_op(6'h00, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    #12;
    check("rst_req", {31'b0, dmem_req}, 32'd0);
    check("rst_stall", {31'b0, STALL}, 32'd0);
    check("rst_wdata", WriteData1_OUT, 32'h0);
    check("rst_rw", {31'b0, RegWrite1_OUT}, 32'd0);
    check("rst_fault", {31'b0, MemFault_OUT}, 32'd0);
    @(negedge CLK) RESET = 1'b1;
    tick;

    // ADD r3
    set_op(6'h00, 32'h1234, 5'd3, 32'h0, 1'b1, 1'b0, 1'b0);
    #1;
    check("add_fwd_reg", {27'b0, MemWriteReg}, 32'd3);
    check("add_fwd_val", Mem_ALU_result, 32'h1234);
    check("add_stall", {31'b0, STALL}, 32'd0);
    tick;
    check("add_wdata", WriteData1_OUT, 32'h1234);
    check("add_wreg", {27'b0, WriteRegister1_OUT}, 32'd3);
    check("add_rw", {31'b0, RegWrite1_OUT}, 32'd1);
    check("add_instr", Instr1_OUT, 32'h1234_A5A5);

    // LW 0x100, ack in the 4th ACCESS cycle (also the timeout cycle: ack wins)
    run_mem(6'h23, 32'h100, 5'd5, 32'h0, 1'b1, 1'b1, 1'b0, 4, 32'hDEAD_BEEF);
    check("lw_stalls", stalls, 32'd4);
    check("lw_reqs", reqs, 32'd4);
    check("lw_fwd_load", {27'b0, cap_fwd}, 32'd0);
    check("lw_be", {28'b0, cap_be}, 32'hF);
    check("lw_addr", cap_addr, 32'h100);
    check("lw_we", {31'b0, cap_we}, 32'd0);
    check("lw_data", WriteData1_OUT, 32'hDEAD_BEEF);
    check("lw_rw", {31'b0, RegWrite1_OUT}, 32'd1);
    check("lw_wreg", {27'b0, WriteRegister1_OUT}, 32'd5);
    check("lw_nofault", {31'b0, MemFault_OUT}, 32'd0);

    // LB / LBU 0x103, same-cycle ack
    run_mem(6'h20, 32'h103, 5'd7, 32'h0, 1'b1, 1'b1, 1'b0, 1, 32'h8012_3456);
    check("lb_stalls", stalls, 32'd1);
    check("lb_be", {28'b0, cap_be}, c_lb_be);
    check("lb_addr", cap_addr, 32'h100);
    check("lb_data", WriteData1_OUT, c_lb_data);
    check("lb_rw", {31'b0, RegWrite1_OUT}, 32'd1);
    run_mem(6'h24, 32'h103, 5'd7, 32'h0, 1'b1, 1'b1, 1'b0, 1, 32'h8012_3456);
    check("lbu_data", WriteData1_OUT, c_lbu_data);

    // SH 0x202
    run_mem(6'h29, 32'h202, 5'd0, 32'h0000_ABCD, 1'b0, 1'b0, 1'b1, 2, 32'h0);
    check("sh_stalls", stalls, 32'd2);
    check("sh_be", {28'b0, cap_be}, c_sh_be);
    check("sh_wdata_hi", {16'b0, cap_wdata[31:16]}, c_sh_hi);
    check("sh_we", {31'b0, cap_we}, 32'd1);
    check("sh_addr", cap_addr, 32'h200);
    check("sh_rw", {31'b0, RegWrite1_OUT}, 32'd0);

    // LW 0x201 (misaligned when subword support is on)
    run_mem(6'h23, 32'h201, 5'd8, 32'h0, 1'b1, 1'b1, 1'b0, 1, 32'h1111_2222);
    check("mis_reqs", reqs, c_mis_reqs);
    check("mis_fault", {31'b0, MemFault_OUT}, c_mis_flt);
    check("mis_rw", {31'b0, RegWrite1_OUT}, c_mis_rw);
    tick;
    check("mis_fault_pulse", {31'b0, MemFault_OUT}, 32'd0);

    // Never ack: timeout after 4 ACCESS cycles
    run_mem(6'h23, 32'h300, 5'd9, 32'h0, 1'b1, 1'b1, 1'b0, 99, 32'h0);
    check("to_reqs", reqs, 32'd4);
    check("to_stalls", stalls, 32'd4);
    check("to_fault", {31'b0, MemFault_OUT}, 32'd1);
    check("to_rw", {31'b0, RegWrite1_OUT}, 32'd0);
    check("to_idle_req", {31'b0, dmem_req}, 32'd0);
    set_op(6'h00, 32'h77, 5'd4, 32'h0, 1'b1, 1'b0, 1'b0);
    tick;
    check("to_add_data", WriteData1_OUT, 32'h77);
    check("to_add_rw", {31'b0, RegWrite1_OUT}, 32'd1);
    check("to_fault_clr", {31'b0, MemFault_OUT}, 32'd0);

    // Reset asserted mid-ACCESS
    set_op(6'h23, 32'h400, 5'd10, 32'h0, 1'b1, 1'b1, 1'b0);
    tick;
    check("mid_req_on", {31'b0, dmem_req}, 32'd1);
    RESET = 1'b0;
    #1;
    check("mid_req_off", {31'b0, dmem_req}, 32'd0);
    check("mid_stall", {31'b0, STALL}, 32'd0);
    check("mid_wdata", WriteData1_OUT, 32'h0);
    check("mid_wreg", {27'b0, WriteRegister1_OUT}, 32'd0);
    check("mid_instr", Instr1_OUT, 32'h0);
    check("mid_addr", dmem_addr, 32'h0);
    set_op(6'h00, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK) RESET = 1'b1;
    tick;
    set_op(6'h00, 32'h55, 5'd9, 32'h0, 1'b1, 1'b0, 1'b0);
    tick;
    check("post_add_data", WriteData1_OUT, 32'h55);
    check("post_add_rw", {31'b0, RegWrite1_OUT}, 32'd1);
    check("post_add_wreg", {27'b0, WriteRegister1_OUT}, 32'd9);
    check("post_req", {31'b0, dmem_req}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
